// File: rtl/fcs_check_sequencer.sv
// Receive-side CRC-32 sequencer: strips preamble/SFD, streams the frame to the engine, reports status.
// Optional FCS_SEQ_STATS_EN adds stats_clr, good_cnt and bad_cnt.
module fcs_check_sequencer #(
   parameter int          PREAMBLE_BYTES  = 8,
   parameter int          MIN_FRAME_BYTES = 64,
   parameter int          MAX_FRAME_BYTES = 1518,
   parameter logic [31:0] GOOD_RESIDUE    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_sof,
   input  logic        rx_eof,
   output logic        crc_init,
   output logic        crc_en,
   output logic [7:0]  crc_data,
   output logic        crc_last,
   input  logic [31:0] crc_residue,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_ok,
   output logic        fcs_err,
   output logic        len_err,
   output logic        sfd_err,
   output logic [10:0] frame_len
`ifdef FCS_SEQ_STATS_EN
   ,
   input  logic        stats_clr,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, BODY, WAIT_RES, REPORT
   } state_t;

   localparam logic [3:0]  SFD_IDX = 4'(PREAMBLE_BYTES - 1);
   localparam logic [10:0] MIN_L   = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] MAX_L   = 11'(MAX_FRAME_BYTES);
   localparam logic [10:0] SAT_L   = 11'(MAX_FRAME_BYTES + 1);

   state_t      state_q, state_d;
   logic [3:0]  pre_cnt_q, pre_cnt_d;
   logic [10:0] len_cnt_q, len_cnt_d;
   logic        sfd_pend_q, sfd_pend_d;
   logic        len_pend_q, len_pend_d;
   logic        body_q, body_d;
   logic        init_q, init_d;
   logic        en_q, en_d;
   logic        last_q, last_d;
   logic [7:0]  data_q, data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        fcs_q, fcs_d;
   logic        len_q, len_d;
   logic        sfd_q, sfd_d;
   logic [10:0] flen_q, flen_d;
   logic [10:0] len_inc;
   logic        len_bad;
   logic        fcs_bad;

   assign len_inc = (len_cnt_q == SAT_L) ? len_cnt_q : len_cnt_q + 11'd1;
   assign len_bad = (len_cnt_q < MIN_L) | (len_cnt_q > MAX_L);
   assign fcs_bad = body_q & (crc_residue != GOOD_RESIDUE);

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      len_cnt_d  = len_cnt_q;
      sfd_pend_d = sfd_pend_q;
      len_pend_d = len_pend_q;
      body_d     = body_q;
      init_d     = 1'b0;
      en_d       = 1'b0;
      last_d     = 1'b0;
      data_d     = data_q;
      done_d     = 1'b0;
      ok_d       = ok_q;
      fcs_d      = fcs_q;
      len_d      = len_q;
      sfd_d      = sfd_q;
      flen_d     = flen_q;
      unique case (state_q)
         IDLE: begin
            if (rx_valid & rx_sof) begin
               state_d    = PREAMBLE;
               pre_cnt_d  = 4'd1;
               len_cnt_d  = '0;
               sfd_pend_d = 1'b0;
               len_pend_d = 1'b0;
               body_d     = 1'b0;
            end
         end
         PREAMBLE: begin
            if (rx_valid) begin
               if (rx_sof) begin
                  pre_cnt_d = 4'd1;
               end else if (rx_eof) begin
                  len_pend_d = 1'b1;
                  state_d    = REPORT;
               end else if (pre_cnt_q == SFD_IDX) begin
                  if (rx_data == 8'hD5) begin
                     init_d    = 1'b1;
                     len_cnt_d = '0;
                     state_d   = BODY;
                  end else begin
                     sfd_pend_d = 1'b1;
                     state_d    = REPORT;
                  end
               end else begin
                  pre_cnt_d = pre_cnt_q + 4'd1;
               end
            end
         end
         BODY: begin
            if (rx_valid) begin
               if (rx_sof) begin
                  // truncated: report now, the SOF byte opens the next preamble
                  done_d     = 1'b1;
                  ok_d       = 1'b0;
                  fcs_d      = 1'b0;
                  len_d      = 1'b1;
                  sfd_d      = 1'b0;
                  flen_d     = len_cnt_q;
                  state_d    = PREAMBLE;
                  pre_cnt_d  = 4'd1;
                  len_cnt_d  = '0;
                  sfd_pend_d = 1'b0;
                  len_pend_d = 1'b0;
                  body_d     = 1'b0;
               end else begin
                  en_d      = 1'b1;
                  data_d    = rx_data;
                  len_cnt_d = len_inc;
                  if (rx_eof) begin
                     last_d  = 1'b1;
                     body_d  = 1'b1;
                     state_d = WAIT_RES;
                  end
               end
            end
         end
         WAIT_RES: state_d = REPORT;
         REPORT: begin
            done_d  = 1'b1;
            fcs_d   = fcs_bad;
            len_d   = len_pend_q | (body_q & len_bad);
            sfd_d   = sfd_pend_q;
            ok_d    = ~(fcs_bad | len_pend_q | (body_q & len_bad) | sfd_pend_q);
            flen_d  = len_cnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         pre_cnt_q  <= '0;
         len_cnt_q  <= '0;
         sfd_pend_q <= 1'b0;
         len_pend_q <= 1'b0;
         body_q     <= 1'b0;
         init_q     <= 1'b0;
         en_q       <= 1'b0;
         last_q     <= 1'b0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         fcs_q      <= 1'b0;
         len_q      <= 1'b0;
         sfd_q      <= 1'b0;
         flen_q     <= '0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         len_cnt_q  <= len_cnt_d;
         sfd_pend_q <= sfd_pend_d;
         len_pend_q <= len_pend_d;
         body_q     <= body_d;
         init_q     <= init_d;
         en_q       <= en_d;
         last_q     <= last_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ok_q       <= ok_d;
         fcs_q      <= fcs_d;
         len_q      <= len_d;
         sfd_q      <= sfd_d;
         flen_q     <= flen_d;
      end
   end

   assign crc_init   = init_q;
   assign crc_en     = en_q;
   assign crc_data   = data_q;
   assign crc_last   = last_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign frame_ok   = ok_q;
   assign fcs_err    = fcs_q;
   assign len_err    = len_q;
   assign sfd_err    = sfd_q;
   assign frame_len  = flen_q;

`ifdef FCS_SEQ_STATS_EN
   logic [15:0] good_q, bad_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         good_q <= '0;
         bad_q  <= '0;
      end else if (stats_clr) begin
         good_q <= '0;
         bad_q  <= '0;
      end else if (done_q) begin
         if (ok_q && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
         if (!ok_q && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
      end
   end

   assign good_cnt = good_q;
   assign bad_cnt  = bad_q;
`endif

endmodule
